// File: rtl/la_lane_mux_wb.sv
// la_lane_mux_wb: Wishbone-controlled per-lane LA source selector with
// source-switch blanking and a snapshot of the registered LA word.
module la_lane_mux_wb #(
    parameter int          NUM_TEAMS    = 12,
    parameter int          LA_WIDTH     = 128,
    parameter int          LANE_WIDTH   = 32,
    parameter int          BLANK_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [LA_WIDTH-1:0] designs_la_data_out [NUM_TEAMS:0],
    output logic [LA_WIDTH-1:0] la_data_out
);
    localparam int SW = $clog2(NUM_TEAMS + 1);
    localparam int NL = LA_WIDTH / LANE_WIDTH;
    localparam int NS = LA_WIDTH / 32;
    localparam int BW = BLANK_CYCLES > 0 ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BLOAD = BW'(BLANK_CYCLES);

    logic                ack_q;
    logic [31:0]         dat_q, dat_d;
    logic                en_q, en_d, pend_q, pend_d, valid_q, valid_d;
    logic [LA_WIDTH-1:0] la_q, la_d, snap_q, snap_d;
    logic [SW-1:0]       sel_q [NL];
    logic [SW-1:0]       sel_d [NL];
    logic [BW-1:0]       blank_q [NL];
    logic [BW-1:0]       blank_d [NL];
    logic                req, hit, wr, wsel_ok, any_blank;
    logic [5:0]          w;
    logic [SW-1:0]       wsel;
    logic                unused_bits;

    assign req     = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign hit     = wbs_adr_i[31:8] == BASE_ADDR[31:8];
    assign w       = wbs_adr_i[7:2];
    assign wr      = req & hit & wbs_we_i & wbs_sel_i[0];
    assign wsel    = wbs_dat_i[SW-1:0];
    assign wsel_ok = wsel <= SW'(NUM_TEAMS);
    assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i, BASE_ADDR[7:0]};

    always_comb begin
        en_d      = en_q;
        pend_d    = 1'b0;
        valid_d   = pend_q ? 1'b1 : valid_q;
        any_blank = 1'b0;
        la_d      = '0;
        dat_d     = '0;
        if (wr && w == 6'd8) begin
            en_d    = wbs_dat_i[0];
            pend_d  = wbs_dat_i[1];
            valid_d = (wbs_dat_i[1] | wbs_dat_i[2]) ? 1'b0 : valid_d;
        end
        for (int i = 0; i < NL; i++) begin
            any_blank = any_blank | (blank_q[i] != '0);
            la_d[i*LANE_WIDTH +: LANE_WIDTH] = (en_q && blank_q[i] == '0) ?
                designs_la_data_out[sel_q[i]][i*LANE_WIDTH +: LANE_WIDTH] : '0;
            sel_d[i]   = sel_q[i];
            blank_d[i] = blank_q[i] != '0 ? blank_q[i] - BW'(1) : '0;
            // Only a real source change restarts the blank window
            if (wr && w == 6'(i) && wsel_ok && wsel != sel_q[i]) begin
                sel_d[i]   = wsel;
                blank_d[i] = BLOAD;
            end
            dat_d = (w == 6'(i)) ? 32'(sel_q[i]) : dat_d;
        end
        for (int k = 0; k < NS; k++)
            dat_d = (w == 6'(16 + k)) ? snap_q[k*32 +: 32] : dat_d;
        dat_d  = (w == 6'd8) ? {31'b0, en_q} : dat_d;
        dat_d  = (w == 6'd9) ? {30'b0, any_blank, valid_q} : dat_d;
        dat_d  = (req && hit && !wbs_we_i) ? dat_d : '0;
        snap_d = pend_q ? la_d : snap_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            en_q    <= 1'b1;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            la_q    <= '0;
            snap_q  <= '0;
            for (int i = 0; i < NL; i++) begin
                sel_q[i]   <= '0;
                blank_q[i] <= '0;
            end
        end else begin
            ack_q   <= req;
            dat_q   <= dat_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            la_q    <= la_d;
            snap_q  <= snap_d;
            for (int i = 0; i < NL; i++) begin
                sel_q[i]   <= sel_d[i];
                blank_q[i] <= blank_d[i];
            end
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign la_data_out = la_q;
endmodule

// File: tb/tb_la_lane_mux_wb.sv
// tb_la_lane_mux_wb: directed Wishbone/LA stimulus; read responses are
// checked by a monitor against a queue of expected values.
module tb_la_lane_mux_wb;
    localparam logic [31:0] B = 32'h3000_0000;
    localparam logic [31:0] A = 32'hA5A5A5A5, C = 32'h3C3C3C3C, X = 32'h66666666;
    localparam logic [127:0] P = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    logic         clk = 0, rst = 1, stb = 0, cyc = 0, we = 0, ack;
    logic [3:0]   sel = 0;
    logic [31:0]  adr = 0, dat = 0, rdat;
    logic [127:0] des [12:0];
    logic [127:0] la;
    int           checks = 0, errors = 0;

    typedef struct { logic rd; logic [31:0] exp; string nm; } exp_t;
    exp_t q[$];
    logic ack_prev = 0;

    la_lane_mux_wb dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat), .designs_la_data_out(des),
        .la_data_out(la)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack) begin
            exp_t e;
            if (ack_prev) begin
                errors++;
                $display("FAIL ack_width ack high on consecutive cycles");
            end
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack no transaction outstanding");
            end else begin
                e = q.pop_front();
                if (e.rd) begin
                    checks++;
                    if (rdat !== e.exp) begin
                        errors++;
                        $display("FAIL %s got %h want %h", e.nm, rdat, e.exp);
                    end
                end
            end
        end else if (rdat !== 32'h0) begin
            errors++;
            $display("FAIL dat_idle got %h want 0", rdat);
        end
        ack_prev = ack;
    end

    task automatic wb(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic [3:0] s, input string nm);
        exp_t e;
        int n = 0;
        @(negedge clk);
        e.rd = !w; e.exp = d; e.nm = nm;
        q.push_back(e);
        adr = a; dat = w ? d : 32'h0; we = w; sel = s; stb = 1; cyc = 1;
        do begin @(negedge clk); n++; end while (!ack && n < 10);
        if (!ack) begin
            errors++;
            $display("FAIL %s_timeout no ack got 0 want 1", nm);
            if (q.size() != 0) void'(q.pop_back());
        end
        stb = 0; cyc = 0; we = 0; sel = 0;
    endtask

    task automatic chk_la(input string nm, input logic [127:0] e);
        checks++;
        if (la !== e) begin
            errors++;
            $display("FAIL %s la got %h want %h", nm, la, e);
        end
    endtask

    initial begin
        for (int d = 0; d < 13; d++) des[d] = {16{d[3:0], d[3:0]}};
        des[0] = {4{A}};
        des[3] = {4{C}};
        repeat (3) @(negedge clk);
        chk_la("reset_zero", 128'h0);
        rst = 0;
        @(negedge clk);
        chk_la("post_reset", {A, A, A, A});
        wb(B + 32'h00, 32'h0, 0, 4'hF, "rd_sel0_rst");
        wb(B + 32'h04, 32'h0, 0, 4'hF, "rd_sel1_rst");
        wb(B + 32'h20, 32'h1, 0, 4'hF, "rd_ctrl_rst");
        wb(B + 32'h24, 32'h0, 0, 4'hF, "rd_status_rst");

        wb(B + 32'h04, 32'd3, 1, 4'hF, "wr_sel1");
        chk_la("sel1_commit", {A, A, A, A});
        @(negedge clk) chk_la("sel1_blank1", {A, A, 32'h0, A});
        @(negedge clk) chk_la("sel1_blank2", {A, A, 32'h0, A});
        @(negedge clk) chk_la("sel1_new", {A, A, C, A});
        wb(B + 32'h04, 32'd3, 0, 4'hF, "rd_sel1");

        wb(B + 32'h00, 32'd13, 1, 4'hF, "wr_sel0_13");
        @(negedge clk) chk_la("rej13_noblank", {A, A, C, A});
        wb(B + 32'h00, 32'd0, 0, 4'hF, "rd_sel0_after13");
        wb(B + 32'h04, 32'd3, 1, 4'hF, "wr_sel1_same");
        @(negedge clk) chk_la("same_noblank", {A, A, C, A});
        wb(B + 32'h04, 32'd5, 1, 4'b1110, "wr_sel1_nosel0");
        @(negedge clk) chk_la("nosel0_ignored", {A, A, C, A});
        wb(B + 32'h104, 32'd6, 1, 4'hF, "wr_oow");
        wb(B + 32'h104, 32'd0, 0, 4'hF, "rd_oow");
        wb(B + 32'h30, 32'd0, 0, 4'hF, "rd_unmapped");
        wb(B + 32'h04, 32'd3, 0, 4'hF, "rd_sel1_kept");

        wb(B + 32'h08, 32'd5, 1, 4'hF, "wr_sel2_5");
        wb(B + 32'h08, 32'd6, 1, 4'hF, "wr_sel2_6");
        fork
            wb(B + 32'h24, 32'h2, 0, 4'hF, "rd_status_blank");
            begin
                chk_la("reload_0", {A, 32'h0, C, A});
                @(negedge clk) chk_la("reload_1", {A, 32'h0, C, A});
                @(negedge clk) chk_la("reload_2", {A, 32'h0, C, A});
                @(negedge clk) chk_la("reload_new", {A, X, C, A});
            end
        join

        @(negedge clk) des[0] = P;
        repeat (2) @(negedge clk);
        chk_la("pattern", {32'h01234567, X, C, 32'h76543210});
        wb(B + 32'h20, 32'h3, 1, 4'hF, "wr_snap");
        wb(B + 32'h40, 32'h76543210, 0, 4'hF, "rd_snap0");
        wb(B + 32'h44, C, 0, 4'hF, "rd_snap1");
        wb(B + 32'h48, X, 0, 4'hF, "rd_snap2");
        wb(B + 32'h4C, 32'h01234567, 0, 4'hF, "rd_snap3");
        wb(B + 32'h24, 32'h1, 0, 4'hF, "rd_status_snap");
        wb(B + 32'h20, 32'h5, 1, 4'hF, "wr_clr");
        wb(B + 32'h24, 32'h0, 0, 4'hF, "rd_status_clr");
        wb(B + 32'h20, 32'h1, 0, 4'hF, "rd_ctrl_clr");

        wb(B + 32'h20, 32'h0, 1, 4'hF, "wr_en0");
        @(negedge clk) chk_la("en0_zero", 128'h0);
        wb(B + 32'h20, 32'h0, 0, 4'hF, "rd_ctrl_en0");

        wb(B + 32'h20, 32'h3, 1, 4'hF, "wr_snap_rst");
        rst = 1;
        repeat (2) @(negedge clk);
        chk_la("rst_mid_zero", 128'h0);
        rst = 0;
        @(negedge clk) chk_la("after_rst", P);
        wb(B + 32'h24, 32'h0, 0, 4'hF, "rd_status_rst2");
        wb(B + 32'h20, 32'h1, 0, 4'hF, "rd_ctrl_rst2");
        wb(B + 32'h04, 32'h0, 0, 4'hF, "rd_sel1_rst2");
        wb(B + 32'h08, 32'h0, 0, 4'hF, "rd_sel2_rst2");
        wb(B + 32'h40, 32'h0, 0, 4'hF, "rd_snap0_rst2");

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
